sd_read_arbiter: RTL and testbench



---
 rtl/sd_arb_pkg.sv | 29 ++
 rtl/sd_read_arbiter_busy_edge.sv | 25 ++
 rtl/sd_read_arbiter.sv | 171 +++++++++++++++++
 tb/tb_sd_read_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_arb_pkg.sv
// Shared types and helpers for the SD sector-read arbiter and its neighbours.
// Holds the FSM state encoding, the default sector size and the round-robin picker.
package sd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        XFER  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int SEC_WORDS_DEF = 256;
    localparam int MAX_REQ       = 4;

    // First valid requester at or after ptr, wrapping modulo nreq. Returns ptr when none is valid.
    function automatic int rr_pick(input logic [MAX_REQ-1:0] valid, input int ptr, input int nreq);
        int idx;
        rr_pick = ptr;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < nreq) begin
                idx = (ptr + k) % nreq;
                if (valid[idx]) begin
                    rr_pick = idx;
                end
            end
        end
    endfunction

endpackage

// File: rtl/sd_read_arbiter_busy_edge.sv
// Two-flop synchronizer for the SD controller busy flag plus a falling-edge detector.
// o_neg is high for one cycle when the synchronized busy drops.
module sd_busy_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_busy,
    output logic o_neg
);

    logic r_d0;
    logic r_d1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_d0 <= 1'b0;
            r_d1 <= 1'b0;
        end else begin
            r_d0 <= i_busy;
            r_d1 <= r_d0;
        end
    end

    assign o_neg = r_d1 & ~r_d0;

endmodule

// File: rtl/sd_read_arbiter.sv
// Round-robin arbiter sharing the SD sector-read port between NREQ burst requesters.
// Whole bursts are granted; each sector is a separate start/busy cycle on the SD controller.
module sd_read_arbiter
    import sd_arb_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int SEC_WORDS = SEC_WORDS_DEF,
    parameter int IDX_W     = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [32*NREQ-1:0] req_sec_addr,
    input  logic [32*NREQ-1:0] req_sec_num,
    output logic [NREQ-1:0]    req_ready,
    output logic               sd_rd_start_en,
    output logic [31:0]        sd_rd_sec_addr,
    input  logic               sd_rd_busy,
    input  logic               sd_rd_val_en,
    input  logic [15:0]        sd_rd_val_data,
    output logic [NREQ-1:0]    out_val_en,
    output logic [15:0]        out_data,
    output logic               out_last,
    output logic [NREQ-1:0]    done,
    output logic [NREQ-1:0]    err,
    output logic               busy,
    output logic [IDX_W-1:0]   grant_idx
);

    localparam int CNT_W = $clog2(SEC_WORDS + 1);
    localparam logic [CNT_W-1:0] WC_FULL = CNT_W'(SEC_WORDS);
    localparam logic [CNT_W-1:0] WC_LAST = CNT_W'(SEC_WORDS - 1);

    state_t           r_state;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_grant;
    logic [31:0]      r_addr;
    logic [31:0]      r_rem;
    logic [CNT_W-1:0] r_wcnt;
    logic             r_start;
    logic [NREQ-1:0]  r_out_val;
    logic [15:0]      r_out_data;
    logic             r_out_last;
    logic [NREQ-1:0]  r_done;
    logic [NREQ-1:0]  r_err;
    logic             r_busy;

    logic               w_neg;
    logic [MAX_REQ-1:0] w_valid4;
    logic [IDX_W-1:0]   w_pick;
    logic [IDX_W-1:0]   w_ptr_next;
    logic [31:0]        w_sel_addr;
    logic [31:0]        w_sel_num;
    logic [NREQ-1:0]    w_req_ready;
    logic [NREQ-1:0]    w_onehot;
    logic [CNT_W-1:0]   w_wcnt_inc;
    logic [CNT_W-1:0]   w_wcnt_end;

    sd_busy_edge u_busy_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_busy (sd_rd_busy),
        .o_neg  (w_neg)
    );

    always_comb begin
        w_valid4 = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_valid4[i] = req_valid[i];
        end
    end

    assign w_pick     = IDX_W'(rr_pick(w_valid4, int'(r_ptr), NREQ));
    assign w_ptr_next = IDX_W'((int'(w_pick) + 1) % NREQ);
    assign w_onehot   = NREQ'(1) << r_grant;

    // req_ready is combinational so the accept pulse coincides with the sampling edge.
    always_comb begin
        w_sel_addr  = '0;
        w_sel_num   = '0;
        w_req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_pick == IDX_W'(i)) begin
                w_sel_addr = req_sec_addr[32*i +: 32];
                w_sel_num  = req_sec_num[32*i +: 32];
                if (rst_n && (r_state == IDLE) && (|req_valid)) begin
                    w_req_ready[i] = 1'b1;
                end
            end
        end
    end

    // A word arriving together with the busy edge still belongs to the ending sector.
    assign w_wcnt_inc = (r_wcnt == WC_FULL) ? r_wcnt : r_wcnt + 1'b1;
    assign w_wcnt_end = sd_rd_val_en ? w_wcnt_inc : r_wcnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_grant    <= '0;
            r_addr     <= '0;
            r_rem      <= '0;
            r_wcnt     <= '0;
            r_start    <= 1'b0;
            r_out_val  <= '0;
            r_out_data <= '0;
            r_out_last <= 1'b0;
            r_done     <= '0;
            r_err      <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_start    <= 1'b0;
            r_out_val  <= '0;
            r_out_last <= 1'b0;
            r_done     <= '0;
            r_err      <= '0;
            case (r_state)
                IDLE: begin
                    if (|req_valid) begin
                        r_grant <= w_pick;
                        r_ptr   <= w_ptr_next;
                        r_addr  <= w_sel_addr;
                        r_rem   <= w_sel_num;
                        r_busy  <= 1'b1;
                        r_state <= (w_sel_num == 32'd0) ? DONE : ISSUE;
                    end
                end
                ISSUE: begin
                    r_start <= 1'b1;
                    r_wcnt  <= '0;
                    r_state <= XFER;
                end
                XFER: begin
                    if (sd_rd_val_en) begin
                        r_out_data <= sd_rd_val_data;
                        r_out_val  <= w_onehot;
                        r_out_last <= (r_rem == 32'd1) && (r_wcnt == WC_LAST);
                    end
                    r_wcnt <= w_wcnt_end;
                    if (w_neg) begin
                        if (w_wcnt_end != WC_FULL) begin
                            r_err <= w_onehot;
                        end
                        r_rem   <= r_rem - 32'd1;
                        r_addr  <= r_addr + 32'd1;
                        r_state <= (r_rem == 32'd1) ? DONE : ISSUE;
                    end
                end
                DONE: begin
                    r_done  <= w_onehot;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready      = w_req_ready;
    assign sd_rd_start_en = r_start;
    assign sd_rd_sec_addr = r_addr;
    assign out_val_en     = r_out_val;
    assign out_data       = r_out_data;
    assign out_last       = r_out_last;
    assign done           = r_done;
    assign err            = r_err;
    assign busy           = r_busy;
    assign grant_idx      = r_grant;

endmodule

// File: tb/tb_sd_read_arbiter.sv
// Self-checking bench for sd_read_arbiter: an SD controller model feeds sectors and a
// scoreboard queue holds the words each granted requester must receive.
module tb_sd_read_arbiter;

  localparam int NREQ  = 2;
  localparam int SW    = 256;
  localparam int IDX_W = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req_valid;
  logic [32*NREQ-1:0] req_sec_addr;
  logic [32*NREQ-1:0] req_sec_num;
  logic [NREQ-1:0]    req_ready;
  logic               sd_rd_start_en;
  logic [31:0]        sd_rd_sec_addr;
  logic               sd_rd_busy;
  logic               sd_rd_val_en;
  logic [15:0]        sd_rd_val_data;
  logic [NREQ-1:0]    out_val_en;
  logic [15:0]        out_data;
  logic               out_last;
  logic [NREQ-1:0]    done;
  logic [NREQ-1:0]    err;
  logic               busy;
  logic [IDX_W-1:0]   grant_idx;

  sd_read_arbiter #(.NREQ(NREQ), .SEC_WORDS(SW), .IDX_W(IDX_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_sec_addr   (req_sec_addr),
    .req_sec_num    (req_sec_num),
    .req_ready      (req_ready),
    .sd_rd_start_en (sd_rd_start_en),
    .sd_rd_sec_addr (sd_rd_sec_addr),
    .sd_rd_busy     (sd_rd_busy),
    .sd_rd_val_en   (sd_rd_val_en),
    .sd_rd_val_data (sd_rd_val_data),
    .out_val_en     (out_val_en),
    .out_data       (out_data),
    .out_last       (out_last),
    .done           (done),
    .err            (err),
    .busy           (busy),
    .grant_idx      (grant_idx)
  );

  // scoreboard: {requester[1:0], last, data[15:0]}
  logic [18:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // bench bookkeeping
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] p_addr[NREQ];
  logic [31:0] p_num[NREQ];
  bit   [NREQ-1:0] clr_pend;
  int   cur_req, cur_num, cur_sec;
  bit   short_en, sd_abort;
  int   start_cnt, val_cnt, last_cnt;
  int   done_cnt[NREQ], err_cnt[NREQ], rdy_cyc[NREQ], done_cyc[NREQ];
  int   gnt_q[$];

  function automatic int gq(input int i);
    return (i < gnt_q.size()) ? gnt_q[i] : 99;
  endfunction

  // driver: post a burst descriptor on requester idx
  task automatic post(input int idx, input logic [31:0] addr, input logic [31:0] num);
    p_addr[idx] = addr;
    p_num[idx]  = num;
    req_sec_addr[32*idx +: 32] = addr;
    req_sec_num[32*idx +: 32]  = num;
    req_valid[idx] = 1'b1;
  endtask

  task automatic wait_done(input int idx, input int target, input int budget);
    int n = 0;
    while (done_cnt[idx] < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("done%0d_within_budget", idx), 32'(done_cnt[idx] >= target), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  // monitor: grants, done/err pulses and the scoreboard pop
  initial begin
    logic [18:0] e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (clr_pend[i]) begin
          req_valid[i] = 1'b0;
          req_sec_addr[32*i +: 32] = 32'hDEAD_0000;
          req_sec_num[32*i +: 32]  = 32'h0000_00FF;
          clr_pend[i] = 1'b0;
        end
      end
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) begin
          gnt_q.push_back(i);
          rdy_cyc[i] = cyc;
          cur_req = i;
          cur_num = int'(p_num[i]);
          cur_sec = 0;
          clr_pend[i] = 1'b1;
        end
        if (done[i]) begin
          done_cnt[i]++;
          done_cyc[i] = cyc;
        end
        if (err[i]) err_cnt[i]++;
      end
      if (out_val_en != '0) begin
        val_cnt++;
        if (out_last) last_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_word", 32'(out_val_en), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("word_req", 32'(out_val_en), 32'(1) << e[18:17]);
          check("word_data", 32'(out_data), 32'(e[15:0]));
          check("word_last", 32'(out_last), 32'(e[16]));
        end
      end else if (out_last) begin
        check("last_without_valid", 32'(out_last), 32'd0);
      end
    end
  end

  // SD controller model: one sector per start pulse, with random gaps between words
  logic [31:0] m_ea;
  int m_nw, m_w;
  bit m_lb;
  initial begin
    sd_rd_busy = 1'b0;
    sd_rd_val_en = 1'b0;
    sd_rd_val_data = '0;
    forever begin
      @(negedge clk);
      if (sd_rd_start_en && rst_n && !sd_abort) begin
        m_ea = p_addr[cur_req] + 32'(cur_sec);
        start_cnt++;
        check("start_addr", sd_rd_sec_addr, m_ea);
        m_nw = SW;
        if (short_en && cur_sec == 0) begin
          m_nw = 200;
          short_en = 1'b0;
        end
        sd_rd_busy = 1'b1;
        m_w = 0;
        while (m_w < m_nw && !sd_abort) begin
          @(negedge clk);
          if (sd_abort) break;
          if ($urandom_range(0, 7) == 0) begin
            sd_rd_val_en = 1'b0;
          end else begin
            sd_rd_val_en = 1'b1;
            sd_rd_val_data = {m_ea[7:0], 8'(m_w)};
            m_lb = (cur_sec == cur_num - 1) && (m_w == SW - 1);
            exp_q.push_back({2'(cur_req), m_lb, sd_rd_val_data});
            m_w++;
          end
        end
        @(negedge clk);
        sd_rd_val_en = 1'b0;
        sd_rd_busy = 1'b0;
        cur_sec++;
      end
    end
  end

  // watchdog
  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // main sequence
  int s0, v0, l0, e0, e1, d0, pc;
  initial begin
    req_valid = '0;
    req_sec_addr = '0;
    req_sec_num = '0;
    clr_pend = '0;
    for (int i = 0; i < NREQ; i++) begin
      done_cnt[i] = 0; err_cnt[i] = 0; p_addr[i] = '0; p_num[i] = '0;
    end

    // reset state
    repeat (3) @(negedge clk);
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant_idx), 32'd0);
    check("rst_start", 32'(sd_rd_start_en), 32'd0);
    check("rst_out_val", 32'(out_val_en), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // contention round 1: pointer 0, req0 then req1
    gnt_q.delete();
    post(0, 32'h10, 32'd1);
    post(1, 32'h20, 32'd2);
    wait_done(0, 1, 2000);
    wait_done(1, 1, 3000);
    check("rr1_count", 32'(gnt_q.size()), 32'd2);
    check("rr1_first", 32'(gq(0)), 32'd0);
    check("rr1_second", 32'(gq(1)), 32'd1);

    // single burst of 3 sectors on req0
    s0 = start_cnt; v0 = val_cnt; l0 = last_cnt; e0 = err_cnt[0];
    post(0, 32'h100, 32'd3);
    wait_done(0, 2, 4000);
    check("t1_starts", 32'(start_cnt - s0), 32'd3);
    check("t1_words", 32'(val_cnt - v0), 32'd768);
    check("t1_last", 32'(last_cnt - l0), 32'd1);
    check("t1_err", 32'(err_cnt[0] - e0), 32'd0);
    check("t1_queue_empty", 32'(exp_q.size()), 32'd0);
    check("t1_idle", 32'(busy), 32'd0);

    // contention round 2: last grant was req0, so req1 now wins first
    gnt_q.delete();
    post(0, 32'h30, 32'd1);
    post(1, 32'h40, 32'd1);
    wait_done(0, 3, 3000);
    check("rr2_count", 32'(gnt_q.size()), 32'd2);
    check("rr2_first", 32'(gq(0)), 32'd1);
    check("rr2_second", 32'(gq(1)), 32'd0);
    check("rr2_done1", 32'(done_cnt[1]), 32'd2);

    // zero-count burst: accept and done, no SD access
    s0 = start_cnt;
    pc = cyc;
    post(1, 32'h50, 32'd0);
    wait_done(1, 3, 20);
    check("zero_ready_cycle", 32'(rdy_cyc[1] - pc), 32'd0);
    check("zero_done_cycle", 32'(done_cyc[1] - rdy_cyc[1]), 32'd2);
    check("zero_no_start", 32'(start_cnt - s0), 32'd0);

    // short first sector: one err, next sector at addr+1 (checked by the model)
    s0 = start_cnt; e0 = err_cnt[0]; e1 = err_cnt[1]; l0 = last_cnt;
    short_en = 1'b1;
    post(0, 32'h300, 32'd2);
    wait_done(0, 4, 3000);
    check("short_err0", 32'(err_cnt[0] - e0), 32'd1);
    check("short_err1", 32'(err_cnt[1] - e1), 32'd0);
    check("short_starts", 32'(start_cnt - s0), 32'd2);
    check("short_last", 32'(last_cnt - l0), 32'd1);

    // reset during sector 2 of 4
    s0 = start_cnt;
    d0 = done_cnt[0];
    post(0, 32'h400, 32'd4);
    pc = 0;
    while (start_cnt < s0 + 2 && pc < 3000) begin
      @(negedge clk);
      pc++;
    end
    check("rst_mid_reached_sector2", 32'(start_cnt - s0), 32'd2);
    repeat (40) @(negedge clk);
    sd_abort = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    #2;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_out_val", 32'(out_val_en), 32'd0);
    check("mid_rst_out_data", 32'(out_data), 32'd0);
    check("mid_rst_last", 32'(out_last), 32'd0);
    check("mid_rst_addr", sd_rd_sec_addr, 32'd0);
    check("mid_rst_grant", 32'(grant_idx), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    sd_abort = 1'b0;
    exp_q.delete();
    repeat (20) @(negedge clk);
    check("mid_rst_no_done", 32'(done_cnt[0] - d0), 32'd0);

    // fresh burst from req1 after reset
    gnt_q.delete();
    post(1, 32'h500, 32'd1);
    wait_done(1, 4, 2000);
    check("post_rst_grant", 32'(gq(0)), 32'd1);
    check("post_rst_grant_idx", 32'(grant_idx), 32'd1);

    // stray data while idle must not be forwarded
    v0 = val_cnt;
    for (int k = 0; k < 3; k++) begin
      sd_rd_val_en = 1'b1;
      sd_rd_val_data = 16'(16'hBEE0 + k);
      @(negedge clk);
    end
    sd_rd_val_en = 1'b0;
    repeat (5) @(negedge clk);
    check("stray_no_word", 32'(val_cnt - v0), 32'd0);
    check("stray_idle", 32'(busy), 32'd0);

    // following burst counts a clean sector
    e0 = err_cnt[0]; l0 = last_cnt; v0 = val_cnt;
    post(0, 32'h600, 32'd1);
    wait_done(0, d0 + 1, 2000);
    check("after_stray_err", 32'(err_cnt[0] - e0), 32'd0);
    check("after_stray_words", 32'(val_cnt - v0), 32'd256);
    check("after_stray_last", 32'(last_cnt - l0), 32'd1);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
